// File: rtl/pixel_strip_seq.sv
// Frame sequencer for an addressable LED strip: holds a colour frame and
// feeds it pixel by pixel to a downstream serialiser, then holds the latch gap.
module pixel_strip_seq #(
    parameter int NUM_PIXELS     = 8,
    parameter int CLK_IN_RATE_HZ = 12_000_000,
    parameter int LATCH_US       = 80,
    parameter int ACK_TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [7:0]  wr_addr,
    input  logic [23:0] wr_data,
    input  logic        start,
    input  logic        pix_busy,
    output logic        pix_valid,
    output logic [7:0]  pixel_r,
    output logic [7:0]  pixel_g,
    output logic [7:0]  pixel_b,
    output logic        seq_busy,
    output logic        done,
    output logic        ack_err
);

    localparam int LATCH_CYCLES = CLK_IN_RATE_HZ / 1_000_000 * LATCH_US;
    localparam int LAT_N   = (LATCH_CYCLES < 1) ? 1 : LATCH_CYCLES;
    localparam int ACK_N   = (ACK_TIMEOUT < 1) ? 1 : ACK_TIMEOUT;
    localparam int CNT_MAX = (LAT_N > ACK_N) ? LAT_N : ACK_N;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;

    localparam logic [IW-1:0] LAST    = IW'(NUM_PIXELS - 1);
    localparam logic [CW-1:0] LAT_END = CW'(LAT_N - 1);
    localparam logic [CW-1:0] ACK_END = CW'(ACK_N - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT_HI,
        WAIT_LO,
        LATCH,
        DONE
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;
    logic [23:0]   mem [NUM_PIXELS];

    // Frame memory is deliberately not reset so a frame survives an abort.
    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_addr) < NUM_PIXELS)) begin
            mem[wr_addr[IW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            pix_valid <= 1'b0;
            pixel_r   <= '0;
            pixel_g   <= '0;
            pixel_b   <= '0;
            seq_busy  <= 1'b0;
            done      <= 1'b0;
            ack_err   <= 1'b0;
        end else begin
            pix_valid <= 1'b0;
            done      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        idx      <= '0;
                        seq_busy <= 1'b1;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    {pixel_r, pixel_g, pixel_b} <= mem[idx];
                    pix_valid <= 1'b1;
                    state     <= ISSUE;
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (pix_busy) begin
                        state <= WAIT_LO;
                    end else if (cnt == ACK_END) begin
                        ack_err <= 1'b1;
                        state   <= WAIT_LO;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAIT_LO: begin
                    if (!pix_busy) begin
                        if (idx == LAST) begin
                            cnt   <= '0;
                            state <= LATCH;
                        end else begin
                            idx   <= idx + IW'(1);
                            state <= FETCH;
                        end
                    end
                end
                LATCH: begin
                    if (cnt == LAT_END) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    seq_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_strip_seq.sv
// Directed bench for pixel_strip_seq: 3-pixel strip, 5-cycle latch,
// 8-cycle acknowledge timeout, with a cycle-stepped serialiser model.
module tb_pixel_strip_seq;

    localparam int NP  = 3;
    localparam int LAT = 5;
    localparam int ACK = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [23:0] wr_data;
    logic        start;
    logic        pix_busy;
    logic        pix_valid;
    logic [7:0]  pixel_r;
    logic [7:0]  pixel_g;
    logic [7:0]  pixel_b;
    logic        seq_busy;
    logic        done;
    logic        ack_err;

    pixel_strip_seq #(
        .NUM_PIXELS    (NP),
        .CLK_IN_RATE_HZ(1_000_000),
        .LATCH_US      (LAT),
        .ACK_TIMEOUT   (ACK)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .start    (start),
        .pix_busy (pix_busy),
        .pix_valid(pix_valid),
        .pixel_r  (pixel_r),
        .pixel_g  (pixel_g),
        .pixel_b  (pixel_b),
        .seq_busy (seq_busy),
        .done     (done),
        .ack_err  (ack_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [23:0] got [8];
    int npix, vhi, done_cnt, fall_c, done_c, err_c, v_c;
    bit fin;

    typedef struct {
        logic [23:0] w0, w1, w2;
        logic [23:0] e0, e1, e2;
    } vec_t;

    vec_t vecs [3];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [23:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_valid"}, 32'(pix_valid), 0);
        chk({nm, "_rgb"}, {8'h0, pixel_r, pixel_g, pixel_b}, 0);
        chk({nm, "_busy"}, 32'(seq_busy), 0);
        chk({nm, "_done"}, 32'(done), 0);
        chk({nm, "_err"}, 32'(ack_err), 0);
    endtask

    // Start a frame and step it cycle by cycle, acting as the serialiser.
    task automatic run_frame(input bit ser, input bit xstart,
                             input bit midwr, input bit abort1);
        int bl;
        int post;
        npix = 0; vhi = 0; done_cnt = 0;
        fall_c = -1; done_c = -1; err_c = -1; v_c = -1;
        bl = 0; post = -1; fin = 0;
        start = 1'b1;
        for (int c = 0; c < 600 && !fin; c++) begin
            @(negedge clk);
            start = 1'b0;
            wr_en = 1'b0;
            if (pix_valid) begin
                vhi++;
                if (npix < 8) got[npix] = {pixel_r, pixel_g, pixel_b};
                npix++;
                if (v_c < 0) v_c = c;
            end
            if (ack_err && err_c < 0) err_c = c;
            if (done) begin
                done_cnt++;
                if (done_c < 0) done_c = c;
                post = c + 12;
                if (xstart) start = 1'b1;
            end
            if (pix_busy) begin
                bl--;
                if (bl == 0) begin
                    pix_busy = 1'b0;
                    fall_c = c;
                end
            end else if (pix_valid && ser) begin
                pix_busy = 1'b1;
                bl = 3;
            end
            if (xstart && c == 0) start = 1'b1;
            if (xstart && npix == NP && fall_c >= 0 && c == fall_c + 2)
                start = 1'b1;
            if (midwr && c == v_c) begin
                wr_en = 1'b1; wr_addr = 8'd0; wr_data = 24'h123456;
            end
            if (midwr && v_c >= 0 && c == v_c + 1) begin
                wr_en = 1'b1; wr_addr = 8'd2; wr_data = 24'hABCDEF;
            end
            if (abort1 && npix == 2 && pix_busy && bl == 1) begin
                rst_n = 1'b0;
                #1;
                chk_zero("abort_now");
                repeat (3) @(negedge clk);
                pix_busy = 1'b0;
                chk_zero("abort_held");
                rst_n = 1'b1;
                fin = 1;
            end
            if (c == post) fin = 1;
        end
        start = 1'b0;
        wr_en = 1'b0;
        pix_busy = 1'b0;
        chk("frame_finished", 32'(fin), 1);
    endtask

    task automatic chk_normal(input string nm, input logic [23:0] e0,
                              input logic [23:0] e1, input logic [23:0] e2);
        chk({nm, "_npix"}, npix, NP);
        chk({nm, "_vhi"}, vhi, NP);
        chk({nm, "_px0"}, 32'(got[0]), 32'(e0));
        chk({nm, "_px1"}, 32'(got[1]), 32'(e1));
        chk({nm, "_px2"}, 32'(got[2]), 32'(e2));
        chk({nm, "_done_cnt"}, done_cnt, 1);
        chk({nm, "_hold_rgb"}, {8'h0, pixel_r, pixel_g, pixel_b}, 32'(e2));
        chk({nm, "_idle"}, 32'(seq_busy), 0);
    endtask

    initial begin
        vecs[0] = '{24'hFF0000, 24'h00FF00, 24'h0000FF,
                    24'hFF0000, 24'h00FF00, 24'h0000FF};
        vecs[1] = '{24'h000000, 24'hFFFFFF, 24'hA5A55A,
                    24'h000000, 24'hFFFFFF, 24'hA5A55A};
        vecs[2] = '{24'h010203, 24'h808080, 24'hFE7F01,
                    24'h010203, 24'h808080, 24'hFE7F01};

        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; pix_busy = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("after_reset");

        for (int i = 0; i < 3; i++) begin
            wr(8'd0, vecs[i].w0);
            wr(8'd1, vecs[i].w1);
            wr(8'd2, vecs[i].w2);
            run_frame(1'b1, 1'b0, 1'b0, 1'b0);
            chk_normal($sformatf("vec%0d", i), vecs[i].e0, vecs[i].e1,
                       vecs[i].e2);
            chk($sformatf("vec%0d_latch", i), done_c - fall_c, LAT + 1);
            chk($sformatf("vec%0d_err", i), 32'(ack_err), 0);
        end

        wr(8'd0, 24'hFF0000);
        wr(8'd1, 24'h00FF00);
        wr(8'd2, 24'h0000FF);
        run_frame(1'b1, 1'b1, 1'b0, 1'b0);
        chk_normal("xstart", 24'hFF0000, 24'h00FF00, 24'h0000FF);
        chk("xstart_latch", done_c - fall_c, LAT + 1);

        run_frame(1'b1, 1'b0, 1'b1, 1'b0);
        chk_normal("midwr", 24'hFF0000, 24'h00FF00, 24'hABCDEF);
        run_frame(1'b1, 1'b0, 1'b0, 1'b0);
        chk_normal("midwr_next", 24'h123456, 24'h00FF00, 24'hABCDEF);

        wr(8'd3, 24'h777777);
        wr(8'd255, 24'h0F0F0F);
        run_frame(1'b1, 1'b0, 1'b0, 1'b0);
        chk_normal("oob_wr", 24'h123456, 24'h00FF00, 24'hABCDEF);

        run_frame(1'b0, 1'b0, 1'b0, 1'b0);
        chk_normal("timeout", 24'h123456, 24'h00FF00, 24'hABCDEF);
        chk("timeout_err", 32'(ack_err), 1);
        chk("timeout_err_cycle", err_c - v_c, ACK + 1);

        run_frame(1'b1, 1'b0, 1'b0, 1'b0);
        chk_normal("sticky", 24'h123456, 24'h00FF00, 24'hABCDEF);
        chk("sticky_err", 32'(ack_err), 1);

        wr(8'd1, 24'h5A5A5A);
        run_frame(1'b1, 1'b0, 1'b0, 1'b1);
        chk("abort_npix", npix, 2);
        chk("abort_done", done_cnt, 0);
        repeat (10) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("abort_no_done", done_cnt, 0);
        chk("abort_idle", 32'(seq_busy), 0);
        run_frame(1'b1, 1'b0, 1'b0, 1'b0);
        chk_normal("post_abort", 24'h123456, 24'h5A5A5A, 24'hABCDEF);
        chk("post_abort_err", 32'(ack_err), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_strip_seq.md
PIXEL_STRIP_SEQ -- requirements
Module: pixel_strip_seq

Interface
REQ-001 The block SHALL have parameter NUM_PIXELS, default 8, meaning the number of pixels in the strip (legal range 1..256).
REQ-002 The block SHALL have parameter CLK_IN_RATE_HZ, default 12_000_000, meaning the input clock frequency.
REQ-003 The block SHALL have parameter LATCH_US, default 80, meaning the minimum low time after the last pixel; LATCH_CYCLES = CLK_IN_RATE_HZ/1_000_000*LATCH_US.
REQ-004 The block SHALL have parameter ACK_TIMEOUT, default 64, meaning the maximum number of cycles to wait for pix_busy to rise after pix_valid.
REQ-005 clk  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 wr_en  input  1  frame-memory write strobe.
REQ-008 wr_addr  input  8  pixel index to write.
REQ-009 wr_data  input  24  pixel colour {r[23:16], g[15:8], b[7:0]}.
REQ-010 start  input  1  single-cycle request to transmit the whole frame.
REQ-011 pix_busy  input  1  busy from the downstream pixel serialiser.
REQ-012 pix_valid  output  1  one-cycle load strobe to the serialiser.
REQ-013 pixel_r, pixel_g, pixel_b  output  8 each  colour presented to the serialiser.
REQ-014 seq_busy  output  1  high whenever the FSM is not in IDLE.
REQ-015 done  output  1  one-cycle pulse at the end of the latch period.
REQ-016 ack_err  output  1  sticky flag: a serialiser acknowledge timeout occurred.

Function
REQ-017 Frame memory SHALL hold NUM_PIXELS x 24 bits; a wr_en write with wr_addr < NUM_PIXELS SHALL update the memory at the next edge in any state.
REQ-018 A write with wr_addr >= NUM_PIXELS SHALL be ignored.
REQ-019 FSM states SHALL be IDLE, FETCH, ISSUE, WAIT_HI, WAIT_LO, LATCH and DONE.
REQ-020 In IDLE, start=1 SHALL clear the pixel index to 0 and go to FETCH; start SHALL be ignored in every other state.
REQ-021 FETCH SHALL register mem[index] onto pixel_r/g/b and go to ISSUE; pixel_r/g/b SHALL hold that value until the next FETCH.
REQ-022 ISSUE SHALL assert pix_valid for exactly one cycle, clear the timeout counter and go to WAIT_HI.
REQ-023 WAIT_HI SHALL go to WAIT_LO when pix_busy=1.
REQ-024 WAIT_HI SHALL set ack_err and go to WAIT_LO when the counter reaches ACK_TIMEOUT cycles without pix_busy.
REQ-025 WAIT_LO SHALL wait for pix_busy=0.
REQ-026 On leaving WAIT_LO with index = NUM_PIXELS-1, the FSM SHALL clear the latch counter and go to LATCH.
REQ-027 On leaving WAIT_LO with any other index, the FSM SHALL increment the index and go to FETCH.
REQ-028 LATCH SHALL hold for LATCH_CYCLES cycles, during which pix_valid=0, then go to DONE.
REQ-029 DONE SHALL pulse done for one cycle and return to IDLE; start in that same cycle SHALL be ignored.
REQ-030 A write to an already-fetched index during a frame SHALL affect only the next frame; a write to a not-yet-fetched index SHALL be sent in the current frame.
REQ-031 Counters SHALL be wide enough for LATCH_CYCLES and ACK_TIMEOUT without wrap.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE and clear pix_valid, seq_busy, done, ack_err, index, the counters and pixel_r/g/b to 0.
REQ-033 Frame memory contents SHALL NOT be reset.
REQ-034 Reset mid-frame SHALL abort the frame with no done pulse.
REQ-035 ack_err SHALL be cleared only by reset.

Verification
REQ-036 NUM_PIXELS=3; write 0:FF0000, 1:00FF00, 2:0000FF; start; model serialiser -> three pix_valid pulses carrying r=FF, g=FF, b=FF in order; done exactly LATCH_CYCLES+1 cycles after the final busy fall; ack_err=0.
REQ-037 Pulse start again at the cycle after the first start and again while in LATCH -> neither request starts a second frame; exactly one done pulse occurs.
REQ-038 Hold pix_busy=0 permanently -> ack_err=1 after ACK_TIMEOUT cycles per pixel; the frame still completes with a done pulse.
REQ-039 During transmission of pixel 0, write index 0 = 123456 and index 2 = ABCDEF -> pixel 0 is sent with its old value and pixel 2 is sent as ABCDEF.
REQ-040 Assert rst_n=0 while in WAIT_LO of pixel 1 -> all outputs are 0 in the same cycle; no done pulse; after release, start sends pixel 0 first.
REQ-041 Write wr_addr=NUM_PIXELS -> frame memory is unchanged.
